// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port integer register file.
// NUM_WR write ports, NUM_RD combinational read ports, optional same-cycle
// write-to-read bypass, entry 0 hardwired to zero. After reset the array is
// cleared one entry per clock (entries 1..2**INDEX-1) while BUSY is high.
// Optional build macro REGFILE_PARITY_EN adds a stored even-parity bit per
// entry, a PERR output per read port and a parity-invert debug hook.
module regfile_mp #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned INDEX  = 5,
   parameter int unsigned NUM_RD = 2,
   parameter int unsigned NUM_WR = 1,
   parameter int unsigned BYPASS = 1
) (
   input  logic                    CLK,
   input  logic                    RST_N,
   input  logic [NUM_WR-1:0]       WE,
   input  logic [NUM_WR*INDEX-1:0] WA,
   input  logic [NUM_WR*XLEN-1:0]  WD,
   input  logic [NUM_RD*INDEX-1:0] RA,
   output logic [NUM_RD*XLEN-1:0]  RD,
   output logic                    BUSY
`ifdef REGFILE_PARITY_EN
   ,
   output logic [NUM_RD-1:0]       PERR
`endif
);

   localparam int unsigned DEPTH = 2**INDEX;

   typedef enum logic {
      ST_CLEAR,
      ST_RUN
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [INDEX-1:0]  r_clr_cnt;
   logic [INDEX-1:0]  w_clr_nxt;
   logic              w_busy;

   logic [XLEN-1:0]   r_mem [DEPTH];

   logic [INDEX-1:0]  w_wa    [NUM_WR];
   logic [XLEN-1:0]   w_wd    [NUM_WR];
   logic [INDEX-1:0]  w_ra    [NUM_RD];
   logic              w_hit   [NUM_RD];
   logic [XLEN-1:0]   w_rdata [NUM_RD];

`ifdef REGFILE_PARITY_EN
   logic              r_par [DEPTH];
   // Test-only hook: when high, the parity bit stored by a write is inverted.
   // Left undriven here; the bench drives it hierarchically.
   logic              w_dbg_par_inv;
`endif

   assign w_busy = (r_state == ST_CLEAR);
   assign BUSY   = w_busy;

   // Unpack the flat port buses into per-port arrays
   always_comb begin
      for (int unsigned p = 0; p < NUM_WR; p++) begin
         w_wa[p] = WA[p*INDEX +: INDEX];
         w_wd[p] = WD[p*XLEN +: XLEN];
      end
      for (int unsigned r = 0; r < NUM_RD; r++) begin
         w_ra[r] = RA[r*INDEX +: INDEX];
      end
   end

   // Clear-sequencer state register; reset restarts the sweep at entry 1
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_state   <= ST_CLEAR;
         r_clr_cnt <= INDEX'(1);
      end else begin
         r_state   <= w_state_nxt;
         r_clr_cnt <= w_clr_nxt;
      end
   end

   // Clear-sequencer next state: advance one entry per edge, leave after the last
   always_comb begin
      w_state_nxt = r_state;
      w_clr_nxt   = r_clr_cnt;
      case (r_state)
         ST_CLEAR: begin
            w_clr_nxt = r_clr_cnt + INDEX'(1);
            if (r_clr_cnt == '1) begin
               w_state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            w_state_nxt = ST_RUN;
         end
         default: begin
            w_state_nxt = ST_CLEAR;
         end
      endcase
   end

   // Storage update: clear sweep while busy, else port writes (later port wins)
   always_ff @(posedge CLK) begin
      if (RST_N) begin
         if (w_busy) begin
            r_mem[r_clr_cnt] <= '0;
`ifdef REGFILE_PARITY_EN
            r_par[r_clr_cnt] <= 1'b0;
`endif
         end else begin
            for (int unsigned p = 0; p < NUM_WR; p++) begin
               if (WE[p] && (w_wa[p] != '0)) begin
                  r_mem[w_wa[p]] <= w_wd[p];
`ifdef REGFILE_PARITY_EN
                  r_par[w_wa[p]] <= (^w_wd[p]) ^ w_dbg_par_inv;
`endif
               end
            end
         end
      end
   end

   // Read ports: zero for x0 / busy, bypass from highest matching write port
   always_comb begin
      RD = '0;
`ifdef REGFILE_PARITY_EN
      PERR = '0;
`endif
      for (int unsigned r = 0; r < NUM_RD; r++) begin
         w_hit[r]   = 1'b0;
         w_rdata[r] = '0;
         if (!w_busy && (w_ra[r] != '0)) begin
            w_rdata[r] = r_mem[w_ra[r]];
            if (BYPASS != 0) begin
               for (int unsigned p = 0; p < NUM_WR; p++) begin
                  if (WE[p] && (w_wa[p] == w_ra[r])) begin
                     w_hit[r]   = 1'b1;
                     w_rdata[r] = w_wd[p];
                  end
               end
            end
`ifdef REGFILE_PARITY_EN
            PERR[r] = !w_hit[r] && ((^r_mem[w_ra[r]]) != r_par[w_ra[r]]);
`endif
         end
         RD[r*XLEN +: XLEN] = w_rdata[r];
      end
   end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: randomized self-checking bench for regfile_mp
// (NUM_WR=2, NUM_RD=2, BYPASS=1) against an array-based reference model.
module tb_regfile_mp;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned INDEX  = 5;
   localparam int unsigned NUM_RD = 2;
   localparam int unsigned NUM_WR = 2;
   localparam int unsigned DEPTH  = 32;

   logic                    CLK = 1'b0;
   logic                    rst_n;
   logic [NUM_WR-1:0]       we;
   logic [NUM_WR*INDEX-1:0] wa;
   logic [NUM_WR*XLEN-1:0]  wd;
   logic [NUM_RD*INDEX-1:0] ra;
   logic [NUM_RD*XLEN-1:0]  rd;
   logic                    busy;
`ifdef REGFILE_PARITY_EN
   logic [NUM_RD-1:0]       perr;
`endif

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   // Reference model: architectural contents, corrupted-parity flags,
   // number of clear edges still to go, and whether reset has been seen.
   logic [XLEN-1:0] model [DEPTH];
   bit              bad   [DEPTH];
   int unsigned     busy_left = 0;
   bit              m_valid   = 1'b0;
   bit              inv_req   = 1'b0;

   always #5 CLK = ~CLK;

   regfile_mp #(
      .XLEN   (XLEN),
      .INDEX  (INDEX),
      .NUM_RD (NUM_RD),
      .NUM_WR (NUM_WR),
      .BYPASS (1)
   ) dut (
      .CLK   (CLK),
      .RST_N (rst_n),
      .WE    (we),
      .WA    (wa),
      .WD    (wd),
      .RA    (ra),
      .RD    (rd),
      .BUSY  (busy)
`ifdef REGFILE_PARITY_EN
      ,
      .PERR  (perr)
`endif
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int unsigned get_wa(int unsigned p);
      return int'(wa[p*INDEX +: INDEX]);
   endfunction

   function automatic int unsigned get_ra(int unsigned r);
      return int'(ra[r*INDEX +: INDEX]);
   endfunction

   function automatic bit wr_hit(int unsigned a);
      bit h = 1'b0;
      for (int unsigned p = 0; p < NUM_WR; p++)
         if (we[p] && get_wa(p) == a) h = 1'b1;
      return h;
   endfunction

   function automatic logic [XLEN-1:0] exp_rd(int unsigned a);
      logic [XLEN-1:0] v;
      if (busy_left > 0 || a == 0) return '0;
      v = model[a];
      for (int unsigned p = 0; p < NUM_WR; p++)
         if (we[p] && get_wa(p) == a) v = wd[p*XLEN +: XLEN];
      return v;
   endfunction

   task automatic set_wr(input int unsigned p, input bit en, input int unsigned a, input logic [XLEN-1:0] d);
      we[p]                = en;
      wa[p*INDEX +: INDEX] = INDEX'(a);
      wd[p*XLEN +: XLEN]   = d;
   endtask

   task automatic set_rd(input int unsigned r, input int unsigned a);
      ra[r*INDEX +: INDEX] = INDEX'(a);
   endtask

   task automatic idle();
      we = '0;
      wa = '0;
      wd = '0;
      ra = '0;
   endtask

   task automatic check_outputs();
      if (!m_valid) return;
      check("BUSY", {63'd0, busy}, {63'd0, busy_left > 0});
      for (int unsigned r = 0; r < NUM_RD; r++) begin
         check($sformatf("RD%0d@%0d", r, get_ra(r)), {32'd0, rd[r*XLEN +: XLEN]},
               {32'd0, exp_rd(get_ra(r))});
`ifdef REGFILE_PARITY_EN
         check($sformatf("PERR%0d@%0d", r, get_ra(r)), {63'd0, perr[r]},
               {63'd0, (busy_left == 0) && get_ra(r) != 0 && !wr_hit(get_ra(r)) && bad[get_ra(r)]});
`endif
      end
   endtask

   task automatic update_model();
      if (!rst_n) begin
         busy_left = DEPTH - 1;
         m_valid   = 1'b1;
      end else if (!m_valid) begin
         // state unknown until the first reset edge
      end else if (busy_left > 0) begin
         busy_left--;
         if (busy_left == 0)
            for (int unsigned a = 0; a < DEPTH; a++) begin
               model[a] = '0;
               bad[a]   = 1'b0;
            end
      end else begin
         for (int unsigned p = 0; p < NUM_WR; p++)
            if (we[p] && get_wa(p) != 0) begin
               model[get_wa(p)] = wd[p*XLEN +: XLEN];
               bad[get_wa(p)]   = inv_req;
            end
      end
   endtask

   // One clock: check combinational outputs, take the edge, return at negedge
   task automatic cycle();
      #1;
      check_outputs();
      @(posedge CLK);
      update_model();
      @(negedge CLK);
   endtask

   task automatic rand_inputs();
      for (int unsigned p = 0; p < NUM_WR; p++)
         set_wr(p, bit'($urandom_range(0, 1)),
                ($urandom_range(0, 1) != 0) ? $urandom_range(0, 7) : $urandom_range(0, 31),
                $urandom);
      for (int unsigned r = 0; r < NUM_RD; r++)
         set_rd(r, ($urandom_range(0, 1) != 0) ? $urandom_range(0, 7) : $urandom_range(0, 31));
   endtask

   task automatic count_busy(input string tag);
      int unsigned cnt = 0;
      while (busy === 1'b1 && cnt < 100) begin
         cycle();
         cnt++;
         rand_inputs();
      end
      idle();
      check(tag, 64'(cnt), 64'(DEPTH - 1));
   endtask

   task automatic read_sweep();
      for (int unsigned a = 1; a < DEPTH; a += 2) begin
         idle();
         set_rd(0, a);
         set_rd(1, (a + 1) % DEPTH);
         #1;
         check($sformatf("clr_zero@%0d", a), {32'd0, rd[XLEN-1:0]}, 64'd0);
         cycle();
      end
   endtask

   initial begin
`ifdef REGFILE_PARITY_EN
      dut.w_dbg_par_inv = 1'b0;
`endif
      for (int unsigned a = 0; a < DEPTH; a++) begin
         model[a] = '0;
         bad[a]   = 1'b0;
      end
      rst_n = 1'b0;
      idle();
      @(negedge CLK);
      repeat (3) cycle();

      // Release with a write attempt at clear cycle 1 (must be ignored)
      rst_n = 1'b1;
      set_wr(0, 1'b1, 3, 32'hA5A5_A5A5);
      count_busy("busy_edges");
      read_sweep();

      // Write then read, with same-cycle bypass
      idle();
      set_wr(0, 1'b1, 5, 32'hDEAD_BEEF);
      set_rd(1, 5);
      #1;
      check("wr_bypass", {32'd0, rd[XLEN +: XLEN]}, 64'h0000_0000_DEAD_BEEF);
      cycle();
      idle();
      set_rd(0, 5);
      #1;
      check("wr_stored", {32'd0, rd[XLEN-1:0]}, 64'h0000_0000_DEAD_BEEF);
      cycle();

      // x0 protection
      idle();
      set_wr(0, 1'b1, 0, 32'hFFFF_FFFF);
      #1;
      check("x0_bypass", {32'd0, rd[XLEN-1:0]}, 64'd0);
      cycle();
      idle();
      #1;
      check("x0_stored", {32'd0, rd[XLEN-1:0]}, 64'd0);
      cycle();

      // Port conflict: higher port wins, both bypass and storage
      idle();
      set_wr(0, 1'b1, 7, 32'h1);
      set_wr(1, 1'b1, 7, 32'h2);
      set_rd(0, 7);
      #1;
      check("conflict_bypass", {32'd0, rd[XLEN-1:0]}, 64'h2);
      cycle();
      idle();
      set_rd(1, 7);
      #1;
      check("conflict_stored", {32'd0, rd[XLEN +: XLEN]}, 64'h2);
      cycle();

      // Random traffic
      for (int unsigned i = 0; i < 400; i++) begin
         rand_inputs();
         cycle();
      end

`ifdef REGFILE_PARITY_EN
      // Corrupt parity of reg[9] through the debug hook
      idle();
      set_wr(0, 1'b1, 9, 32'h0000_0001);
      inv_req = 1'b1;
      dut.w_dbg_par_inv = 1'b1;
      cycle();
      dut.w_dbg_par_inv = 1'b0;
      inv_req = 1'b0;
      idle();
      set_rd(0, 9);
      set_rd(1, 5);
      #1;
      check("perr9", {63'd0, perr[0]}, 64'd1);
      cycle();
      // A bypass hit on the corrupted entry hides the error
      set_wr(1, 1'b1, 9, 32'h3);
      cycle();
      idle();
      set_rd(0, 9);
      cycle();
`endif

      // Reset in the middle of the clear sequence restarts it
      rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
      repeat (10) begin
         rand_inputs();
         cycle();
      end
      rst_n = 1'b0;
      idle();
      cycle();
      rst_n = 1'b1;
      count_busy("busy_edges_restart");
      read_sweep();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file for the RV32I/M core. Generalises the single-write/dual-read file to NUM_WR write ports and NUM_RD read ports.
- Adds write-to-read bypass, deterministic port priority, and a sequenced hardware clear after reset.
- Sits between decode (read addresses) and writeback (write ports). Supports dual-issue and future M-unit writeback.

Parameters:
- XLEN, 32, data width in bits.
- INDEX, 5, address width; depth = 2**INDEX registers, entry 0 hardwired to zero.
- NUM_RD, 2, number of read ports (1..4).
- NUM_WR, 1, number of write ports (1..2).
- BYPASS, 1, 1 = a same-cycle write to a read address is forwarded to RD; 0 = RD shows the stored value.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST_N  input  1  reset, synchronous, active-low; starts the clear sequence.
- WE  input  NUM_WR  per-port write enable.
- WA  input  NUM_WR*INDEX  write addresses; port p occupies bits [p*INDEX +: INDEX].
- WD  input  NUM_WR*XLEN  write data; port p occupies bits [p*XLEN +: XLEN].
- RA  input  NUM_RD*INDEX  read addresses, packed the same way as WA.
- RD  output  NUM_RD*XLEN  read data (combinational from RA).
- BUSY  output  1  high while reset is asserted or the clear sequence runs.
- PERR  output  NUM_RD  per-read-port parity error (present only with REGFILE_PARITY_EN).

Behaviour:
- Reset: one clock, CLK. Reset is synchronous and active-low on RST_N. Any rising edge with RST_N=0 sets clr_cnt=1 and BUSY=1; array contents are not touched in that cycle.
- Clear sequence: each rising edge with RST_N=1 and BUSY=1 writes 0 to reg[clr_cnt] and increments clr_cnt.
  - The edge that clears reg[2**INDEX-1] also sets BUSY=0.
  - BUSY is therefore high for exactly 2**INDEX-1 edges after reset release (31 edges at default).
- RST_N low mid-sequence restarts the sequence at clr_cnt=1.
- While BUSY=1:
  - WE is ignored; no architectural write occurs.
  - RD = 0 on all ports.
  - PERR = 0.
- Write: on the rising edge with BUSY=0, for each p with WE[p]=1 and WA[p]!=0, reg[WA[p]] <= WD[p].
  - Writes to address 0 are discarded.
  - Two ports writing the same nonzero address in one cycle: the highest-numbered port wins.
- Read: RD[r] = 0 when RA[r]==0; otherwise the value is combinational.
  - BYPASS=1: if any enabled write port targets RA[r] this cycle, RD[r] = WD of the highest-numbered such port; otherwise RD[r] = reg[RA[r]].
  - BYPASS=0: RD[r] = reg[RA[r]]; a write is visible to reads on the following cycle.
  - Bypass is suppressed while BUSY=1 and for address 0.
- Write latency: 1 cycle to storage; 0 cycles to RD with BYPASS=1.
- Reset value of every output: RD=0, BUSY=1, PERR=0.
- No X propagation: all array entries are defined once BUSY falls.

Optional Feature:
- Macro: REGFILE_PARITY_EN.
- Defined:
  - Each entry stores an extra even-parity bit, computed from the write data on every write (clear writes parity 0).
  - PERR[r] = 1 when RA[r]!=0, BUSY=0, no bypass hit on port r, and the stored parity mismatches the stored data.
  - A hidden parity-invert debug hook is added for test only, driven by a bench-visible internal signal that flips the stored parity bit on the next write.
- Undefined: no parity storage, PERR is removed from the port list, and area matches the plain array.

Test Plan:
- Reset/clear: hold RST_N=0 for 3 cycles, release -> BUSY=1 for exactly 31 edges, then 0; every RD reads 0 for RA=1..31.
- Write then read: WE[0]=1, WA=5, WD=32'hDEADBEEF; next cycle RA[0]=5 -> RD[0]=32'hDEADBEEF. With BYPASS=1, RA[1]=5 in the same cycle as the write -> RD[1]=32'hDEADBEEF.
- x0 protection: write WA=0, WD=32'hFFFFFFFF -> RD reads 0 at RA=0, with no bypass.
- Port conflict (NUM_WR=2): WA[0]=WA[1]=7, WD0=32'h1, WD1=32'h2 -> reg[7]=32'h2 and the bypassed RD=32'h2.
- Write during BUSY: release reset, assert WE with WA=3, WD=32'hA5A5A5A5 at clear cycle 1 (before clr_cnt reaches 3) -> after BUSY falls, RD at RA=3 is 0.
- Reset mid-clear: drop RST_N at clear cycle 10 for 1 cycle -> BUSY stays high for 31 further edges after release. With REGFILE_PARITY_EN, invert a stored parity bit on reg[9] -> PERR asserts for the port reading RA=9.
